router_pe_port: RTL and testbench

Router-side endpoint of the PE link that the NIC drives. It is the receiver for the NIC's network output channel (NIC so/ro/do) and the transmitter for the NIC's network input channel (NIC si/ri/di). Each direction has a two-entry even/odd virtual-channel (VC) buffer, arbitrated by the router's polarity bit. The block also generates that polarity bit. Its internal side connects to the router crossbar through a req/gnt interface (inbound) and a req/rdy interface (outbound).

---
 rtl/router_pe_port.sv | 104 ++++++++++
 tb/tb_router_pe_port.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/router_pe_port.sv
// Router-side endpoint of the NIC PE link: two-entry even/odd VC buffers per direction,
// with the NIC side on VC=polarity and the crossbar side on VC=~polarity.
module router_pe_port #(
  parameter int unsigned PACKET_WIDTH = 64,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    polarity,
  input  logic                    pe_si,
  output logic                    pe_ri,
  input  logic [0:PACKET_WIDTH-1] pe_di,
  output logic                    pe_so,
  input  logic                    pe_ro,
  output logic [0:PACKET_WIDTH-1] pe_do,
  output logic                    xb_out_req,
  input  logic                    xb_out_gnt,
  output logic [0:PACKET_WIDTH-1] xb_out_data,
  input  logic                    xb_in_req,
  output logic                    xb_in_rdy,
  input  logic [0:PACKET_WIDTH-1] xb_in_data,
  output logic [CNT_WIDTH-1:0]    rx_count,
  output logic [CNT_WIDTH-1:0]    tx_count
);

  logic                    polarity_q;
  logic [0:PACKET_WIDTH-1] in_buf_q  [0:1];
  logic [0:PACKET_WIDTH-1] out_buf_q [0:1];
  logic [1:0]              in_full_q, in_full_d;
  logic [1:0]              out_full_q, out_full_d;
  logic [CNT_WIDTH-1:0]    rx_count_q, rx_count_d;
  logic [CNT_WIDTH-1:0]    tx_count_q, tx_count_d;

  logic ext_vc, int_vc;
  logic rx_fire, drain_fire, fill_fire, tx_fire;

  // The two sides always index opposite entries, so fill and drain never collide.
  assign ext_vc = polarity_q;
  assign int_vc = ~polarity_q;

  assign rx_fire    = pe_si && !in_full_q[ext_vc];
  assign drain_fire = in_full_q[int_vc] && xb_out_gnt;
  assign fill_fire  = xb_in_req && !out_full_q[int_vc];
  assign tx_fire    = out_full_q[ext_vc] && pe_ro;

  always_comb begin
    in_full_d  = in_full_q;
    out_full_d = out_full_q;
    rx_count_d = rx_count_q;
    tx_count_d = tx_count_q;
    if (rx_fire) begin
      in_full_d[ext_vc] = 1'b1;
      rx_count_d        = rx_count_q + CNT_WIDTH'(1);
    end
    if (drain_fire) begin
      in_full_d[int_vc] = 1'b0;
    end
    if (fill_fire) begin
      out_full_d[int_vc] = 1'b1;
    end
    if (tx_fire) begin
      out_full_d[ext_vc] = 1'b0;
      tx_count_d         = tx_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_q   <= 1'b0;
      in_full_q    <= '0;
      out_full_q   <= '0;
      rx_count_q   <= '0;
      tx_count_q   <= '0;
      in_buf_q[0]  <= '0;
      in_buf_q[1]  <= '0;
      out_buf_q[0] <= '0;
      out_buf_q[1] <= '0;
    end else begin
      polarity_q <= ~polarity_q;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
      if (rx_fire) begin
        in_buf_q[ext_vc] <= pe_di;
      end
      if (fill_fire) begin
        out_buf_q[int_vc] <= xb_in_data;
      end
    end
  end

  // Emptiness comes from the flags only; stale data is masked so an all-zero packet is still legal.
  assign polarity    = polarity_q;
  assign pe_ri       = ~in_full_q[ext_vc];
  assign xb_out_req  = in_full_q[int_vc];
  assign xb_out_data = in_full_q[int_vc] ? in_buf_q[int_vc] : '0;
  assign xb_in_rdy   = ~out_full_q[int_vc];
  assign pe_so       = out_full_q[ext_vc];
  assign pe_do       = out_full_q[ext_vc] ? out_buf_q[ext_vc] : '0;
  assign rx_count    = rx_count_q;
  assign tx_count    = tx_count_q;

endmodule

// File: tb/tb_router_pe_port.sv
// Directed bench for router_pe_port: reset, inbound/outbound handshakes, back-pressure,
// concurrent VC traffic with an all-zero packet, and asynchronous mid-operation reset.
module tb_router_pe_port;

  localparam int unsigned PW = 64;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          polarity;
  logic          pe_si, pe_ri, pe_so, pe_ro;
  logic [0:PW-1] pe_di, pe_do;
  logic          xb_out_req, xb_out_gnt, xb_in_req, xb_in_rdy;
  logic [0:PW-1] xb_out_data, xb_in_data;
  logic [CW-1:0] rx_count, tx_count;

  int n_checks = 0;
  int n_fail   = 0;

  router_pe_port #(.PACKET_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .pe_si(pe_si), .pe_ri(pe_ri), .pe_di(pe_di),
    .pe_so(pe_so), .pe_ro(pe_ro), .pe_do(pe_do),
    .xb_out_req(xb_out_req), .xb_out_gnt(xb_out_gnt), .xb_out_data(xb_out_data),
    .xb_in_req(xb_in_req), .xb_in_rdy(xb_in_rdy), .xb_in_data(xb_in_data),
    .rx_count(rx_count), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; pe_si = 1'b1; pe_di = 64'hFF; pe_ro = 1'b0;
    xb_out_gnt = 1'b0; xb_in_req = 1'b0; xb_in_data = '0;
    repeat (3) next_cycle();
    check("rst_polarity", 64'(polarity), 64'd0);
    check("rst_pe_ri", 64'(pe_ri), 64'd1);
    check("rst_pe_so", 64'(pe_so), 64'd0);
    check("rst_pe_do", pe_do, 64'd0);
    check("rst_xb_out_req", 64'(xb_out_req), 64'd0);
    check("rst_xb_out_data", xb_out_data, 64'd0);
    check("rst_xb_in_rdy", 64'(xb_in_rdy), 64'd1);
    check("rst_rx_count", 64'(rx_count), 64'd0);
    check("rst_tx_count", 64'(tx_count), 64'd0);

    // C0 (pol 0): NIC sends 0xA5 into VC0
    reset = 1'b1; pe_si = 1'b1; pe_di = 64'h00000000_000000A5;
    next_cycle(); // C1 pol 1
    check("in_polarity_c1", 64'(polarity), 64'd1);
    check("in_req", 64'(xb_out_req), 64'd1);
    check("in_data", xb_out_data, 64'hA5);
    check("in_rx_count", 64'(rx_count), 64'd1);
    check("in_pe_ri_vc1", 64'(pe_ri), 64'd1);
    pe_si = 1'b0;
    next_cycle(); // C2 pol 0: VC0 still full
    check("bp_pe_ri", 64'(pe_ri), 64'd0);
    check("bp_req_other_vc", 64'(xb_out_req), 64'd0);
    pe_si = 1'b1; pe_di = 64'hBB;
    next_cycle(); // C3 pol 1
    check("bp_rx_count", 64'(rx_count), 64'd1);
    check("bp_req_held", 64'(xb_out_req), 64'd1);
    check("bp_data_held", xb_out_data, 64'hA5);
    pe_si = 1'b0; xb_out_gnt = 1'b1;
    next_cycle(); // C4 pol 0: VC0 drained
    check("gnt_pe_ri", 64'(pe_ri), 64'd1);
    check("gnt_req_vc1", 64'(xb_out_req), 64'd0);
    xb_out_gnt = 1'b0;
    next_cycle(); // C5 pol 1
    check("gnt_req_vc0", 64'(xb_out_req), 64'd0);
    check("gnt_data_zero", xb_out_data, 64'd0);
    check("out_rdy_vc0", 64'(xb_in_rdy), 64'd1);
    xb_in_req = 1'b1; xb_in_data = 64'h1234;
    next_cycle(); // C6 pol 0
    check("out_pe_so", 64'(pe_so), 64'd1);
    check("out_pe_do", pe_do, 64'h1234);
    check("out_rdy_vc1", 64'(xb_in_rdy), 64'd1);
    xb_in_req = 1'b0; pe_ro = 1'b0;
    next_cycle(); // C7 pol 1
    check("out_pe_so_vc1", 64'(pe_so), 64'd0);
    check("out_rdy_vc0_full", 64'(xb_in_rdy), 64'd0);
    next_cycle(); // C8 pol 0: held
    check("hold_pe_so_1", 64'(pe_so), 64'd1);
    check("hold_pe_do_1", pe_do, 64'h1234);
    check("hold_tx_1", 64'(tx_count), 64'd0);
    next_cycle(); // C9 pol 1
    next_cycle(); // C10 pol 0: still held
    check("hold_pe_so_2", 64'(pe_so), 64'd1);
    check("hold_pe_do_2", pe_do, 64'h1234);
    check("hold_tx_2", 64'(tx_count), 64'd0);
    pe_ro = 1'b1;
    next_cycle(); // C11 pol 1
    check("tx_count_1", 64'(tx_count), 64'd1);
    next_cycle(); // C12 pol 0
    check("tx_done_pe_so", 64'(pe_so), 64'd0);
    check("tx_done_rdy", 64'(xb_in_rdy), 64'd1);
    next_cycle(); // C13 pol 1: inbound VC1 and outbound VC0 (zero packet) together
    pe_si = 1'b1; pe_di = 64'h5A5A;
    xb_in_req = 1'b1; xb_in_data = '0;
    next_cycle(); // C14 pol 0
    check("cc_rx_count", 64'(rx_count), 64'd2);
    check("cc_req", 64'(xb_out_req), 64'd1);
    check("cc_data", xb_out_data, 64'h5A5A);
    check("cc_zero_pe_so", 64'(pe_so), 64'd1);
    check("cc_zero_pe_do", pe_do, 64'd0);
    pe_si = 1'b0; xb_in_req = 1'b0; xb_out_gnt = 1'b1; pe_ro = 1'b1;
    next_cycle(); // C15 pol 1
    check("cc_tx_count", 64'(tx_count), 64'd2);
    check("cc_rx_count_2", 64'(rx_count), 64'd2);
    xb_out_gnt = 1'b0; pe_ro = 1'b0;
    next_cycle(); // C16 pol 0
    check("cc_req_cleared", 64'(xb_out_req), 64'd0);
    check("cc_pe_so_cleared", 64'(pe_so), 64'd0);

    // Fill all four entries
    pe_si = 1'b1; pe_di = 64'h11; xb_in_req = 1'b1; xb_in_data = 64'h22;
    next_cycle(); // C17 pol 1
    pe_di = 64'h33; xb_in_data = 64'h44;
    next_cycle(); // C18 pol 0
    pe_si = 1'b0; xb_in_req = 1'b0;
    check("full_pe_ri", 64'(pe_ri), 64'd0);
    check("full_pe_do", pe_do, 64'h44);
    check("full_xb_data", xb_out_data, 64'h33);
    check("full_xb_in_rdy", 64'(xb_in_rdy), 64'd0);
    check("full_rx_count", 64'(rx_count), 64'd4);
    #2 reset = 1'b0;
    #1;
    check("mr_pe_so", 64'(pe_so), 64'd0);
    check("mr_pe_do", pe_do, 64'd0);
    check("mr_xb_out_req", 64'(xb_out_req), 64'd0);
    check("mr_pe_ri", 64'(pe_ri), 64'd1);
    check("mr_xb_in_rdy", 64'(xb_in_rdy), 64'd1);
    check("mr_rx_count", 64'(rx_count), 64'd0);
    check("mr_tx_count", 64'(tx_count), 64'd0);
    check("mr_polarity", 64'(polarity), 64'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle(); // pol 1: opposite entries also empty
    check("mr2_polarity", 64'(polarity), 64'd1);
    check("mr2_pe_so", 64'(pe_so), 64'd0);
    check("mr2_xb_out_req", 64'(xb_out_req), 64'd0);
    check("mr2_pe_ri", 64'(pe_ri), 64'd1);
    check("mr2_xb_in_rdy", 64'(xb_in_rdy), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
